// File: rtl/arb_wrr_slot.sv
// Weighted round-robin arbiter: one owner holds the grant for a slot of up to W cycles.
// Latency: one cycle from request to grant; slot hand-over happens with no idle cycle.
// No downstream backpressure; requesters wait with req held high until granted.
module arb_wrr_slot #(
  parameter  int REQ_NUM  = 4,
  parameter  int WEIGHT_W = 4,
  localparam int ID_W     = $clog2(REQ_NUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REQ_NUM-1:0]           req,
  input  logic [REQ_NUM*WEIGHT_W-1:0]  cfg_weight,
  output logic [REQ_NUM-1:0]           grant,
  output logic                         grant_vld,
  output logic [ID_W-1:0]              grant_id,
  output logic                         preempt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [WEIGHT_W-1:0] r_slot_cnt;
  logic [REQ_NUM-1:0]  r_grant;
  logic                r_grant_vld;
  logic [ID_W-1:0]     r_grant_id;
  logic                r_preempt;

  // r_grant_id doubles as the owner index while BUSY
  logic                  w_owner_req;
  logic [ID_W-1:0]       w_owner_nxt;
  logic                  w_expire;
  logic                  w_release;
  logic [ID_W-1:0]       w_scan_ptr;
  logic [2*REQ_NUM-1:0]  w_req_rot;
  logic [ID_W:0]         w_sum;
  logic                  w_found;
  logic [ID_W-1:0]       w_winner;
  logic [REQ_NUM-1:0]    w_win_oh;
  logic [WEIGHT_W-1:0]   w_wt_raw;
  logic [WEIGHT_W-1:0]   w_slot_load;

  // Owner's current request bit and the index one past the owner (wrapping)
  always_comb begin
    w_owner_req = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (r_grant_id == ID_W'(i)) begin
        w_owner_req = req[i];
      end
    end
    w_owner_nxt = (r_grant_id == ID_W'(REQ_NUM - 1)) ? '0 : r_grant_id + ID_W'(1);
    w_expire    = (r_slot_cnt == '0);
    w_release   = (r_state == ST_BUSY) && (!w_owner_req || w_expire);
    // At a release the scan already starts past the outgoing owner
    w_scan_ptr  = (r_state == ST_BUSY) ? w_owner_nxt : r_ptr;
  end

  // First set request at or after the scan pointer, wrapping around the top
  always_comb begin
    w_req_rot = {req, req} >> w_scan_ptr;
    w_found   = 1'b0;
    w_winner  = '0;
    w_sum     = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, w_scan_ptr} + (ID_W+1)'(i);
        if (w_sum >= (ID_W+1)'(REQ_NUM)) begin
          w_sum = w_sum - (ID_W+1)'(REQ_NUM);
        end
        w_winner = w_sum[ID_W-1:0];
      end
    end
  end

  // Winner one-hot and its slot length; a zero weight behaves as one cycle
  always_comb begin
    w_win_oh = '0;
    w_wt_raw = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (w_found && (w_winner == ID_W'(i))) begin
        w_win_oh[i] = 1'b1;
        w_wt_raw    = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
      end
    end
    w_slot_load = (w_wt_raw == '0) ? '0 : w_wt_raw - WEIGHT_W'(1);
  end

  // Arbitration FSM: grant, id, valid and preempt all move at the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_slot_cnt  <= '0;
      r_grant     <= '0;
      r_grant_vld <= 1'b0;
      r_grant_id  <= '0;
      r_preempt   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_preempt <= 1'b0;
          if (w_found) begin
            r_state     <= ST_BUSY;
            r_grant     <= w_win_oh;
            r_grant_vld <= 1'b1;
            r_grant_id  <= w_winner;
            r_slot_cnt  <= w_slot_load;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_ptr     <= w_owner_nxt;
            r_preempt <= w_expire && w_owner_req;
            if (w_found) begin
              r_grant     <= w_win_oh;
              r_grant_vld <= 1'b1;
              r_grant_id  <= w_winner;
              r_slot_cnt  <= w_slot_load;
            end else begin
              r_state     <= ST_IDLE;
              r_grant     <= '0;
              r_grant_vld <= 1'b0;
              r_grant_id  <= '0;
              r_slot_cnt  <= '0;
            end
          end else begin
            r_slot_cnt <= r_slot_cnt - WEIGHT_W'(1);
            r_preempt  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_vld = r_grant_vld;
  assign grant_id  = r_grant_id;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_arb_wrr_slot.sv
// Self-checking bench for arb_wrr_slot: directed scenarios plus randomized traffic
// checked against a slot-level reference model (owner, cycles held, weight, pointer).
module tb_arb_wrr_slot;

  localparam int N  = 4;
  localparam int WW = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*WW-1:0] cfg_weight;
  logic [N-1:0]  grant;
  logic          grant_vld;
  logic [1:0]    grant_id;
  logic          preempt;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  int         m_owner;
  int         m_held;
  int         m_w;
  int         m_ptr;
  logic [3:0] exp_grant;
  logic [1:0] exp_id;
  logic       exp_vld;
  logic       exp_pre;

  arb_wrr_slot #(.REQ_NUM(N), .WEIGHT_W(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .cfg_weight (cfg_weight),
    .grant      (grant),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id),
    .preempt    (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int eff_w(input int i);
    int w;
    w = int'(cfg_weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic void model_reset();
    m_owner   = -1;
    m_held    = 0;
    m_w       = 0;
    m_ptr     = 0;
    exp_grant = '0;
    exp_id    = '0;
    exp_vld   = 1'b0;
    exp_pre   = 1'b0;
  endfunction

  // One clock edge of the arbitration rules, evaluated on the request vector r
  function automatic void model_step(input logic [3:0] r);
    exp_pre = 1'b0;
    if (m_owner >= 0) begin
      if (r[m_owner] && m_held < m_w) begin
        m_held++;
      end else begin
        exp_pre = r[m_owner] && (m_held >= m_w);
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    if (m_owner < 0 && r != 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      m_w    = eff_w(m_owner);
      m_held = 1;
    end
    exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    exp_id    = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    exp_vld   = (m_owner >= 0);
  endfunction

  task automatic tick(input logic [3:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req   = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_cmp++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", grant_vld); end
    n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", grant_id); end
    n_cmp++; if (preempt !== 1'b0) begin n_fail++; $display("FAIL reset_preempt: got %b want 0", preempt); end
    req = 4'b1111;
    @(posedge clk);
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_hold_grant: got %b want 0000", grant); end
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_rr_w1();
    logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    cfg_weight = 16'h1111;
    for (int k = 0; k < 5; k++) begin
      tick(4'b1111);
      n_cmp++; if (grant !== eg[k]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, eg[k]); end
      n_cmp++; if (grant_id !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, grant_id, k % 4); end
      n_cmp++; if (preempt !== (k > 0)) begin n_fail++; $display("FAIL rr_preempt[%0d]: got %b want %b", k, preempt, (k > 0)); end
    end
  endtask

  task automatic test_weighted();
    logic [3:0] eg [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    logic       ep [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd3};
    for (int k = 0; k < 8; k++) begin
      tick(4'b0011);
      n_cmp++; if (grant !== eg[k]) begin n_fail++; $display("FAIL wt_grant[%0d]: got %b want %b", k, grant, eg[k]); end
      n_cmp++; if (preempt !== ep[k]) begin n_fail++; $display("FAIL wt_preempt[%0d]: got %b want %b", k, preempt, ep[k]); end
    end
  endtask

  task automatic test_voluntary();
    apply_reset();
    cfg_weight = {4'd1, 4'd5, 4'd1, 4'd1};
    for (int k = 0; k < 2; k++) begin
      tick(4'b0100);
      n_cmp++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL vol_grant[%0d]: got %b want 0100", k, grant); end
    end
    tick(4'b0000);
    n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL vol_release: got %b want 0000", grant); end
    n_cmp++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL vol_vld: got %b want 0", grant_vld); end
    n_cmp++; if (preempt !== 1'b0) begin n_fail++; $display("FAIL vol_preempt: got %b want 0", preempt); end
    tick(4'b1001);
    n_cmp++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL vol_next: got %b want 1000", grant); end
    n_cmp++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL vol_next_id: got %0d want 3", grant_id); end
  endtask

  task automatic test_zero_weight();
    apply_reset();
    cfg_weight = {4'd1, 4'd1, 4'd0, 4'd1};
    for (int k = 0; k < 6; k++) begin
      tick(4'b0010);
      n_cmp++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL zw_grant[%0d]: got %b want 0010", k, grant); end
      n_cmp++; if (preempt !== (k > 0)) begin n_fail++; $display("FAIL zw_preempt[%0d]: got %b want %b", k, preempt, (k > 0)); end
    end
  endtask

  task automatic test_reset_mid_slot();
    apply_reset();
    cfg_weight = {4'd1, 4'd1, 4'd3, 4'd1};
    tick(4'b0100);
    tick(4'b0010);
    n_cmp++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rst_mid_owner: got %b want 0010", grant); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_async_grant: got %b want 0000", grant); end
    n_cmp++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async_vld: got %b want 0", grant_vld); end
    n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_mid_async_id: got %0d want 0", grant_id); end
    req = 4'b0000;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    req = 4'b1010;
    model_step(req);
    @(posedge clk);
    #1;
    n_cmp++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rst_mid_regrant: got %b want 0010", grant); end
    n_cmp++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL rst_mid_regrant_id: got %0d want 1", grant_id); end
  endtask

  task automatic test_random();
    logic [3:0] rr;
    logic [3:0] prev_grant;
    int         run;
    int         waitc [N];
    int         bound;
    for (int blk = 0; blk < 10; blk++) begin
      tick(4'b0000);
      for (int i = 0; i < N; i++) begin
        cfg_weight[i*WW +: WW] = 4'($urandom_range(0, 5));
        waitc[i] = 0;
      end
      rr         = 4'($urandom_range(0, 15));
      prev_grant = grant;
      run        = 0;
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 7) == 0) rr[i] = ~rr[i];
        end
        tick(rr);
        n_cmp++; if (grant !== exp_grant) begin n_fail++; $display("FAIL rnd_grant[%0d.%0d]: got %b want %b", blk, c, grant, exp_grant); end
        n_cmp++; if (grant_vld !== exp_vld) begin n_fail++; $display("FAIL rnd_vld[%0d.%0d]: got %b want %b", blk, c, grant_vld, exp_vld); end
        n_cmp++; if (grant_id !== exp_id) begin n_fail++; $display("FAIL rnd_id[%0d.%0d]: got %0d want %0d", blk, c, grant_id, exp_id); end
        n_cmp++; if (preempt !== exp_pre) begin n_fail++; $display("FAIL rnd_preempt[%0d.%0d]: got %b want %b", blk, c, preempt, exp_pre); end
        n_cmp++; if ($countones(grant) > 1) begin n_fail++; $display("FAIL rnd_onehot[%0d.%0d]: got %b want at most one bit", blk, c, grant); end
        if (grant == 4'b0000) run = 0;
        else if (grant != prev_grant || preempt) run = 1;
        else run++;
        prev_grant = grant;
        if (grant != 4'b0000) begin
          n_cmp++; if (run > eff_w(int'(grant_id))) begin n_fail++; $display("FAIL rnd_hold[%0d.%0d]: held %0d want <= %0d", blk, c, run, eff_w(int'(grant_id))); end
        end
        for (int i = 0; i < N; i++) begin
          if (rr[i] && !grant[i]) waitc[i]++;
          else waitc[i] = 0;
          bound = 1;
          for (int j = 0; j < N; j++) if (j != i) bound += eff_w(j);
          n_cmp++; if (waitc[i] > bound) begin n_fail++; $display("FAIL rnd_starve[%0d.%0d] req%0d: waited %0d want <= %0d", blk, c, i, waitc[i], bound); end
        end
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    cfg_weight = 16'h1111;
    model_reset();
    test_reset();
    test_rr_w1();
    test_weighted();
    test_voluntary();
    test_zero_weight();
    test_reset_mid_slot();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
